// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg -- shared datapath types for the CPU pipeline stages.
// Revision 1.0
`default_nettype none

package cpu_types_pkg;

   typedef logic [31:0] word_t;
   typedef logic [4:0]  regbits_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DONE = 2'd2
   } memstate_t;

endpackage

`default_nettype wire

// File: rtl/mem_stage_if.sv
// mem_stage_if -- data-cache request/response bundle between MEM stage and D-cache.
// Revision 1.0
`default_nettype none

interface mem_stage_if;
   import cpu_types_pkg::*;

   logic  dmemREN;
   logic  dmemWEN;
   word_t dmemaddr;
   word_t dmemstore;
   logic  dhit;
   word_t dmemload;

   modport master (
      output dmemREN, dmemWEN, dmemaddr, dmemstore,
      input  dhit, dmemload
   );

   modport slave (
      input  dmemREN, dmemWEN, dmemaddr, dmemstore,
      output dhit, dmemload
   );

endinterface

`default_nettype wire

// File: rtl/mem_stage_llsc_link.sv
// llsc_link -- LL/SC link register with external invalidate and SC address compare.
// Revision 1.0
`default_nettype none

module llsc_link
   import cpu_types_pkg::*;
(
   input  logic  CLK,
   input  logic  RST,
   input  logic  sc_in,
   input  word_t cmp_addr,
   output logic  sc_fail,
   input  logic  ll_done,
   input  logic  sc_done,
   input  word_t done_addr,
   input  logic  inv_valid,
   input  word_t inv_addr
);

   logic  r_link_valid;
   word_t r_link_addr;
   logic  w_inv_hit;

   assign w_inv_hit = inv_valid & (inv_addr == r_link_addr);
   assign sc_fail   = sc_in & ~(r_link_valid & (r_link_addr == cmp_addr));

   // A completing LL re-arms the link even if an invalidate hits in the same cycle.
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_link_valid <= 1'b0;
         r_link_addr  <= '0;
      end else if (ll_done) begin
         r_link_valid <= 1'b1;
         r_link_addr  <= done_addr;
      end else if (sc_done | w_inv_hit) begin
         r_link_valid <= 1'b0;
      end
   end

endmodule

`default_nettype wire

// File: rtl/mem_stage.sv
// mem_stage -- MEM pipeline stage: D-cache request FSM, load buffer, LL/SC and stall counter.
// Revision 1.0
`default_nettype none

module mem_stage
   import cpu_types_pkg::*;
(
   input  logic  CLK,
   input  logic  RST,
   input  logic  valid_in,
   input  logic  MemRead_in,
   input  logic  MemWrite_in,
   input  logic  LL_in,
   input  logic  SC_in,
   input  word_t aluOutport_in,
   input  word_t storedata_in,
   input  logic  flush,
   input  logic  hold_in,
   input  logic  inv_valid,
   input  word_t inv_addr,
   mem_stage_if.master dcif,
   output word_t dmemload_out,
   output word_t sc_result,
   output logic  mem_stall,
   output logic  memwb_wen,
   output word_t stall_cycles
);

   localparam logic [1:0] ST_IDLE = 2'(IDLE);
   localparam logic [1:0] ST_WAIT = 2'(WAIT);
   localparam logic [1:0] ST_DONE = 2'(DONE);

   logic [1:0] r_state;
   logic [1:0] w_next;

   logic  r_ren;
   logic  r_wen;
   logic  r_ll;
   logic  r_sc;
   word_t r_addr;
   word_t r_store;
   word_t r_buf;
   word_t r_sc_result;
   word_t r_stall_cycles;

   logic  w_sc_fail;
   logic  w_live;
   logic  w_ren;
   logic  w_wen;
   word_t w_addr;
   word_t w_store;
   logic  w_done;
   logic  w_stall;
   logic  w_wb;
   logic  w_ll;
   logic  w_sc;
   logic  w_sc_ok;
   logic  w_bypass;

   assign w_live = valid_in & ~flush & (MemRead_in | MemWrite_in);

   always_comb begin
      w_next  = r_state;
      w_ren   = 1'b0;
      w_wen   = 1'b0;
      w_addr  = '0;
      w_store = '0;
      w_done  = 1'b0;
      w_stall = 1'b0;
      w_wb    = 1'b0;
      w_ll    = 1'b0;
      w_sc    = 1'b0;
      w_sc_ok = 1'b0;
      case (r_state)
         ST_IDLE: begin
            w_ren = w_live & MemRead_in;
            w_wen = w_live & MemWrite_in & ~w_sc_fail;
            if (w_live) begin
               w_addr  = aluOutport_in;
               w_store = storedata_in;
            end
            // A failing SC never reaches the cache, so it completes here with no hit.
            w_done  = w_live & (~(w_ren | w_wen) | dcif.dhit);
            w_stall = (w_ren | w_wen) & ~dcif.dhit;
            w_wb    = ~w_stall & ~hold_in;
            w_ll    = LL_in;
            w_sc    = SC_in;
            w_sc_ok = SC_in & ~w_sc_fail;
            if (w_done & hold_in) begin
               w_next = ST_DONE;
            end else if (w_stall) begin
               w_next = ST_WAIT;
            end
         end
         ST_WAIT: begin
            w_ren   = r_ren;
            w_wen   = r_wen;
            w_addr  = r_addr;
            w_store = r_store;
            w_done  = dcif.dhit;
            w_stall = ~dcif.dhit;
            w_wb    = dcif.dhit;
            w_ll    = r_ll;
            w_sc    = r_sc;
            w_sc_ok = r_sc;
            if (dcif.dhit) begin
               w_next = hold_in ? ST_DONE : ST_IDLE;
            end
         end
         ST_DONE: begin
            if (!hold_in) begin
               w_next = ST_IDLE;
            end
         end
         default: begin
            w_next = ST_IDLE;
         end
      endcase
      if (RST) begin
         w_ren   = 1'b0;
         w_wen   = 1'b0;
         w_addr  = '0;
         w_store = '0;
         w_done  = 1'b0;
         w_stall = 1'b0;
      end
   end

   assign w_bypass = w_done & w_ren;

   llsc_link u_link (
      .CLK       (CLK),
      .RST       (RST),
      .sc_in     (SC_in),
      .cmp_addr  (aluOutport_in),
      .sc_fail   (w_sc_fail),
      .ll_done   (w_done & w_ll),
      .sc_done   (w_done & w_sc),
      .done_addr (w_addr),
      .inv_valid (inv_valid),
      .inv_addr  (inv_addr)
   );

   assign dcif.dmemREN   = w_ren;
   assign dcif.dmemWEN   = w_wen;
   assign dcif.dmemaddr  = w_addr;
   assign dcif.dmemstore = w_store;

   assign dmemload_out = w_bypass ? dcif.dmemload : r_buf;
   assign sc_result    = (w_done & w_sc) ? {31'b0, w_sc_ok} : r_sc_result;
   assign mem_stall    = w_stall;
   assign memwb_wen    = w_wb;
   assign stall_cycles = r_stall_cycles;

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state        <= ST_IDLE;
         r_ren          <= 1'b0;
         r_wen          <= 1'b0;
         r_ll           <= 1'b0;
         r_sc           <= 1'b0;
         r_addr         <= '0;
         r_store        <= '0;
         r_buf          <= '0;
         r_sc_result    <= '0;
         r_stall_cycles <= '0;
      end else begin
         r_state <= w_next;
         // Freeze the request at issue so it stays stable for the whole miss.
         if ((r_state == ST_IDLE) && w_stall) begin
            r_ren   <= w_ren;
            r_wen   <= w_wen;
            r_ll    <= w_ll;
            r_sc    <= w_sc;
            r_addr  <= w_addr;
            r_store <= w_store;
         end
         if (w_bypass) begin
            r_buf <= dcif.dmemload;
         end
         if (w_done & w_sc) begin
            r_sc_result <= {31'b0, w_sc_ok};
         end
         if (w_stall) begin
            r_stall_cycles <= r_stall_cycles + 32'd1;
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_mem_stage.sv
// tb_mem_stage -- directed plus randomized transaction-level checks of mem_stage.
// Revision 1.0
`default_nettype none

module tb_mem_stage;
   import cpu_types_pkg::*;

   localparam int K_NOP = 0;
   localparam int K_LW  = 1;
   localparam int K_SW  = 2;
   localparam int K_LL  = 3;
   localparam int K_SC  = 4;

   logic  CLK = 1'b0;
   logic  RST;
   logic  valid_in, MemRead_in, MemWrite_in, LL_in, SC_in, flush, hold_in, inv_valid;
   word_t aluOutport_in, storedata_in, inv_addr;
   word_t dmemload_out, sc_result, stall_cycles;
   logic  mem_stall, memwb_wen;

   mem_stage_if dif ();

   mem_stage dut (
      .CLK           (CLK),
      .RST           (RST),
      .valid_in      (valid_in),
      .MemRead_in    (MemRead_in),
      .MemWrite_in   (MemWrite_in),
      .LL_in         (LL_in),
      .SC_in         (SC_in),
      .aluOutport_in (aluOutport_in),
      .storedata_in  (storedata_in),
      .flush         (flush),
      .hold_in       (hold_in),
      .inv_valid     (inv_valid),
      .inv_addr      (inv_addr),
      .dcif          (dif.master),
      .dmemload_out  (dmemload_out),
      .sc_result     (sc_result),
      .mem_stall     (mem_stall),
      .memwb_wen     (memwb_wen),
      .stall_cycles  (stall_cycles)
   );

   always #5 CLK = ~CLK;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model state: memory image, link register, load buffer, last SC outcome, stall total.
   word_t m_mem [word_t];
   bit    m_link_valid;
   word_t m_link_addr;
   word_t m_buf;
   word_t m_scres;
   word_t m_stall;

   task automatic chk(input string tag, input word_t obs, input word_t exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic word_t rd_mem(input word_t a);
      return m_mem.exists(a) ? m_mem[a] : (a ^ 32'hA5A5_5A5A);
   endfunction

   task automatic clear_inputs();
      valid_in = 0; MemRead_in = 0; MemWrite_in = 0; LL_in = 0; SC_in = 0;
      flush = 0; hold_in = 0; inv_valid = 0; inv_addr = '0;
      aluOutport_in = '0; storedata_in = '0;
      dif.dhit = 0; dif.dmemload = $urandom;
   endtask

   task automatic do_reset();
      @(posedge CLK); #1;
      clear_inputs();
      RST = 1;
      @(negedge CLK);
      chk("rst_ren", dif.dmemREN, 0);
      chk("rst_wen", dif.dmemWEN, 0);
      chk("rst_stall", mem_stall, 0);
      @(posedge CLK); #1;
      RST = 0;
      m_link_valid = 0; m_link_addr = '0; m_buf = '0; m_scres = '0; m_stall = '0;
      @(negedge CLK);
      chk("post_rst_ren", dif.dmemREN, 0);
      chk("post_rst_stall", mem_stall, 0);
      chk("post_rst_stall_cycles", stall_cycles, m_stall);
      chk("post_rst_load_out", dmemload_out, m_buf);
      chk("post_rst_sc_result", sc_result, m_scres);
      chk("post_rst_memwb_wen", memwb_wen, 1);
   endtask

   task automatic idle_cycle();
      @(posedge CLK); #1;
      clear_inputs();
      @(negedge CLK);
      chk("idle_ren", dif.dmemREN, 0);
      chk("idle_stall", mem_stall, 0);
      chk("idle_memwb_wen", memwb_wen, 1);
      chk("idle_load_out", dmemload_out, m_buf);
   endtask

   task automatic flushed_op(input word_t addr);
      @(posedge CLK); #1;
      clear_inputs();
      valid_in = 1; MemRead_in = 1; aluOutport_in = addr; flush = 1;
      @(negedge CLK);
      chk("flush_ren", dif.dmemREN, 0);
      chk("flush_stall", mem_stall, 0);
      chk("flush_memwb_wen", memwb_wen, 1);
   endtask

   // One instruction: issue, lat cycles of miss, completion, then hold_n cycles parked in DONE.
   task automatic run_op(input int kind, input word_t addr, input word_t data, input int lat,
                         input int hold_n, input bit inv_en, input word_t inv_a);
      bit rd, wr, ll, sc, memop, sc_fail, issued, hold_now;
      int lat_e;
      word_t ld;
      rd = (kind == K_LW) || (kind == K_LL);
      wr = (kind == K_SW) || (kind == K_SC);
      ll = (kind == K_LL);
      sc = (kind == K_SC);
      memop = rd || wr;
      sc_fail = sc && !(m_link_valid && (m_link_addr == addr));
      issued = memop && !sc_fail;
      lat_e = issued ? lat : 0;
      if (!memop) hold_n = 0;
      ld = rd_mem(addr);
      for (int k = 0; k <= lat_e; k++) begin
         @(posedge CLK); #1;
         if (k == 0) begin
            valid_in = 1; MemRead_in = rd; MemWrite_in = wr; LL_in = ll; SC_in = sc;
            aluOutport_in = addr; storedata_in = data; flush = 0;
         end else begin
            flush = 1'($urandom_range(0, 1));
         end
         dif.dhit = issued && (k == lat_e);
         dif.dmemload = (k == lat_e) ? ld : $urandom;
         hold_now = (k == lat_e) && (hold_n > 0);
         hold_in = hold_now;
         inv_valid = (k == lat_e) && inv_en;
         inv_addr = inv_a;
         @(negedge CLK);
         if (k == 0) chk("stall_cycles", stall_cycles, m_stall);
         chk("dmemREN", dif.dmemREN, issued && rd);
         chk("dmemWEN", dif.dmemWEN, issued && wr);
         if (issued) chk("dmemaddr", dif.dmemaddr, addr);
         if (issued && wr) chk("dmemstore", dif.dmemstore, data);
         chk("mem_stall", mem_stall, issued && (k < lat_e));
         if (k == lat_e) begin
            chk("memwb_wen_done", memwb_wen, (lat_e > 0) ? 1'b1 : !hold_now);
            chk("dmemload_out", dmemload_out, (issued && rd) ? ld : m_buf);
            chk("sc_result", sc_result, sc ? word_t'(!sc_fail) : m_scres);
         end else begin
            chk("memwb_wen_stall", memwb_wen, 0);
         end
      end
      m_stall += word_t'(lat_e);
      if (issued && rd) m_buf = ld;
      if (issued && wr) m_mem[addr] = data;
      if (sc) m_scres = word_t'(!sc_fail);
      if (ll) begin
         m_link_valid = 1; m_link_addr = addr;
      end else begin
         if (sc) m_link_valid = 0;
         if (inv_en && (inv_a == m_link_addr)) m_link_valid = 0;
      end
      for (int d = 1; d <= hold_n; d++) begin
         @(posedge CLK); #1;
         inv_valid = 0; dif.dhit = 0; flush = 0; dif.dmemload = $urandom;
         hold_in = (d < hold_n);
         @(negedge CLK);
         chk("hold_ren", dif.dmemREN, 0);
         chk("hold_wen", dif.dmemWEN, 0);
         chk("hold_stall", mem_stall, 0);
         chk("hold_memwb_wen", memwb_wen, 0);
         chk("hold_load_out", dmemload_out, m_buf);
         chk("hold_sc_result", sc_result, m_scres);
      end
   endtask

   function automatic word_t pick_addr();
      case ($urandom_range(0, 3))
         0: return 32'h300;
         1: return 32'h304;
         2: return 32'h308;
         default: return $urandom;
      endcase
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int kind;
      word_t a;
      RST = 1;
      clear_inputs();
      m_mem[32'h100] = 32'hDEAD_BEEF;
      do_reset();

      // Load miss with three stall cycles.
      run_op(K_LW, 32'h100, '0, 3, 0, 0, '0);
      idle_cycle();
      chk("lw_stall_count", stall_cycles, m_stall);
      // Store hit with no stall.
      run_op(K_SW, 32'h200, 32'h1234_5678, 0, 0, 0, '0);
      // LL / SC pair, then a second SC that must fail.
      run_op(K_LL, 32'h300, '0, 1, 0, 0, '0);
      run_op(K_SC, 32'h300, 32'hCAFE_0001, 2, 0, 0, '0);
      run_op(K_SC, 32'h300, 32'hCAFE_0002, 0, 0, 0, '0);
      // LL broken by an external invalidate.
      run_op(K_LL, 32'h300, '0, 0, 0, 0, '0);
      run_op(K_NOP, '0, '0, 0, 0, 1, 32'h300);
      run_op(K_SC, 32'h300, 32'hCAFE_0003, 1, 0, 0, '0);
      // Load completing in WAIT under a two-cycle freeze.
      run_op(K_LW, 32'h200, '0, 2, 2, 0, '0);
      idle_cycle();
      // Invalidate coinciding with LL completion: the LL keeps the link.
      run_op(K_LL, 32'h300, '0, 0, 0, 0, '0);
      run_op(K_LL, 32'h500, '0, 1, 0, 1, 32'h300);
      run_op(K_SC, 32'h500, 32'hBEEF_0005, 0, 1, 0, '0);
      flushed_op(32'h100);
      // Reset while waiting on a miss.
      run_op(K_LL, 32'h300, '0, 0, 0, 0, '0);
      @(posedge CLK); #1;
      valid_in = 1; MemRead_in = 1; MemWrite_in = 0; LL_in = 0; SC_in = 0;
      aluOutport_in = 32'h100; dif.dhit = 0; hold_in = 0; inv_valid = 0; flush = 0;
      @(negedge CLK);
      chk("pre_rst_stall0", mem_stall, 1);
      @(posedge CLK); #1;
      @(negedge CLK);
      chk("pre_rst_stall1", mem_stall, 1);
      do_reset();
      run_op(K_SC, 32'h300, 32'h0BAD_0BAD, 0, 0, 0, '0);

      for (int i = 0; i < 200; i++) begin
         kind = $urandom_range(0, 6);
         if (kind == 5) kind = K_LL;
         if (kind == 6) kind = K_SC;
         a = pick_addr();
         if ($urandom_range(0, 9) == 0) begin
            flushed_op(a);
         end else begin
            run_op(kind, a, $urandom, $urandom_range(0, 3),
                   ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0,
                   1'($urandom_range(0, 4) == 0), pick_addr());
         end
      end
      idle_cycle();
      chk("final_stall_count", stall_cycles, m_stall);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire
